// File: rtl/seq_divider_6by3.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional SEQ_DIVIDER_DZ_DETECT_EN: divide-by-zero finishes at once and raises dz.
module seq_divider_6by3 #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           dz
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  // Dividend bits shift out at the top while quotient bits shift in at the bottom.
  logic [W-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  r_q, r_d;
  logic [W-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
  logic          dz_q, dz_d;
`endif

  logic [N:0]    trial;
  logic [N:0]    diff;
  logic          fits;

  assign trial = {r_q, dvd_q[W-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign fits  = (trial >= {1'b0, dvs_q});

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    r_d         = r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
    dz_d        = dz_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          r_d     = '0;
          count_d = '0;
          state_d = S_BUSY;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
          dz_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend[N-1:0];
            dz_d        = 1'b1;
            state_d     = S_DONE;
          end
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_BUSY: begin
        r_d     = fits ? diff[N-1:0] : trial[N-1:0];
        dvd_d   = {dvd_q[W-2:0], fits};
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          quotient_d  = {dvd_q[W-2:0], fits};
          remainder_d = fits ? diff[N-1:0] : trial[N-1:0];
          state_d     = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      r_q         <= r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
      dz_q        <= dz_d;
`endif
    end
  end

  assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
  assign dz        = dz_q;
`else
  assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_6by3.sv
// Self-checking bench for seq_divider_6by3: directed scenarios plus a shuffled sweep of every
// nonzero-divisor pair against a plain-arithmetic reference model.
module tb_seq_divider_6by3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       ready;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       dz;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_DIVIDER_DZ_DETECT_EN
  localparam int  DZ_LAT = 1;
  localparam logic DZ_EXP = 1'b1;
`else
  localparam int  DZ_LAT = 7;
  localparam logic DZ_EXP = 1'b0;
`endif

  seq_divider_6by3 #(.N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  // Reference: integer division; a zero divisor yields all-ones quotient and the low dividend bits.
  function automatic void model(input int a, input int d, output int q, output int r);
    if (d == 0) begin
      q = 63;
      r = a % 8;
    end else begin
      q = a / d;
      r = a % d;
    end
  endfunction

  // Called at a negedge while ready; returns at the negedge of the done cycle (or after a timeout).
  task automatic do_div(input int a, input int d, output int lat,
                        output logic [5:0] q, output logic [2:0] r, output logic z);
    dividend = 6'(a);
    divisor  = 3'(d);
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
    z = dz;
  endtask

  task automatic check_div(input string name, input int a, input int d, input int exp_lat);
    int lat, eq, er;
    logic [5:0] q;
    logic [2:0] r;
    logic z;
    logic exp_z;
    model(a, d, eq, er);
    exp_z = (d == 0) ? DZ_EXP : 1'b0;
    do_div(a, d, lat, q, r, z);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (q !== 6'(eq) || r !== 3'(er)) begin
      errors++;
      $display("FAIL %s result: got q=%0d r=%0d expected q=%0d r=%0d", name, q, r, eq, er);
    end
    checks++;
    if (z !== exp_z) begin
      errors++;
      $display("FAIL %s dz: got %b expected %b", name, z, exp_z);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    checks++;
    if ({ready, done, dz, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 6'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b done=%b dz=%b q=%0d r=%0d expected 1 0 0 0 0",
               ready, done, dz, quotient, remainder);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got ready=%b done=%b expected 1 0", ready, done);
    end
  endtask

  task automatic test_basic();
    check_div("basic_42_5", 42, 5, 7);
  endtask

  task automatic test_extremes();
    check_div("ext_63_1", 63, 1, 7);
    check_div("ext_7_7", 7, 7, 7);
    check_div("ext_0_3", 0, 3, 7);
    check_div("ext_62_7", 62, 7, 7);
  endtask

  // Start pulsed mid-division must neither restart nor disturb the held previous result.
  task automatic test_ignore_busy();
    int lat;
    logic [5:0] prev_q;
    logic [2:0] prev_r;
    prev_q = quotient;
    prev_r = remainder;
    dividend = 6'd42; divisor = 3'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    @(negedge clk); lat++;
    @(negedge clk); lat++;
    dividend = 6'd9; divisor = 3'd2; start = 1'b1;
    checks++;
    if (ready !== 1'b0 || quotient !== prev_q || remainder !== prev_r) begin
      errors++;
      $display("FAIL busy_hold: got ready=%b q=%0d r=%0d expected 0 q=%0d r=%0d",
               ready, quotient, remainder, prev_q, prev_r);
    end
    @(negedge clk); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 7 || quotient !== 6'd8 || remainder !== 3'd2) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d expected 7 8 2", lat, quotient, remainder);
    end
  endtask

  // Start held high: the DONE cycle re-accepts and the next division begins with no idle gap.
  task automatic test_back_to_back();
    int lat, ready_busy;
    dividend = 6'd42; divisor = 3'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 6'd63; divisor = 3'd1;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 7 || quotient !== 6'd8 || remainder !== 3'd2) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected 7 8 2", lat, quotient, remainder);
    end
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    ready_busy = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (ready !== 1'b0) ready_busy++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 7 || ready_busy !== 0 || quotient !== 6'd63 || remainder !== 3'd0) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d ready_in_busy=%0d q=%0d r=%0d expected 7 0 63 0",
               lat, ready_busy, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_op();
    dividend = 6'd45; divisor = 3'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, done, dz, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 6'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_mid_op: got ready=%b done=%b dz=%b q=%0d r=%0d expected 1 0 0 0 0",
               ready, done, dz, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_div("after_reset_45_6", 45, 6, 7);
  endtask

  task automatic test_div_zero();
    check_div("div_zero_45_0", 45, 0, DZ_LAT);
    check_div("dz_clear_42_5", 42, 5, 7);
  endtask

  // Every nonzero-divisor pair in shuffled order with random idle gaps.
  task automatic test_random_sweep();
    int pairs[$];
    int lat, eq, er, tmp, j, bad;
    logic [5:0] q;
    logic [2:0] r;
    logic z;
    for (int a = 0; a < 64; a++)
      for (int d = 1; d < 8; d++)
        pairs.push_back(a * 8 + d);
    for (int i = pairs.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
    end
    bad = 0;
    foreach (pairs[i]) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      do_div(pairs[i] / 8, pairs[i] % 8, lat, q, r, z);
      model(pairs[i] / 8, pairs[i] % 8, eq, er);
      checks++;
      if (lat !== 7 || q !== 6'(eq) || r !== 3'(er) || z !== 1'b0 ||
          int'(q) * (pairs[i] % 8) + int'(r) != pairs[i] / 8 || int'(r) >= pairs[i] % 8) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep_%0d_%0d: got lat=%0d q=%0d r=%0d dz=%b expected 7 q=%0d r=%0d dz=0",
                   pairs[i] / 8, pairs[i] % 8, lat, q, r, z, eq, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_div_zero();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider_6by3.md
Name: seq_divider_6by3

Overview:
- Sequential unsigned restoring divider; the inverse of the team's 3x3 array multiplier.
- Accepts a 2N-bit dividend and an N-bit divisor; produces a 2N-bit quotient and an N-bit remainder.
- Resolves one quotient bit per clock.
- Used wherever a multiplier product must be split back into factors. Single clock domain, start/done handshake.

Parameters:
- N, 3, divisor width and remainder width; dividend and quotient are 2N bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; accepted only when ready=1.
- dividend  input  2N  unsigned dividend, sampled on the accepting edge.
- divisor  input  N  unsigned divisor, sampled on the accepting edge.
- ready  output  1  high in IDLE and DONE (can accept start).
- done  output  1  one-cycle pulse: quotient/remainder valid.
- quotient  output  2N  result quotient.
- remainder  output  N  result remainder.
- dz  output  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- Reset (async, any state, including mid-division):
  - state=IDLE; ready=1.
  - done=0, dz=0, quotient=0, remainder=0.
  - Internal shift/count registers cleared.
- States:
  - IDLE: ready=1. On start=1, latch operands, clear partial remainder, count=0, go to BUSY.
  - BUSY: ready=0. Each cycle performs one restoring step, MSB of dividend first:
    - t = {r, next dividend bit} (N+1 bits).
    - If t >= {0,divisor}: r = (t - divisor)[N-1:0], quotient bit = 1.
    - Else: r = t[N-1:0], quotient bit = 0.
    - count increments. After 2N steps, go to DONE.
  - DONE: done=1 for exactly this cycle; ready=1. Next cycle: IDLE. A start in DONE is accepted exactly as in IDLE (go to BUSY).
- Latency:
  - start sampled at edge k; BUSY occupies cycles k+1..k+2N.
  - done=1 during cycle k+2N+1.
  - Default N=3: 6 busy cycles, done on the 7th cycle after acceptance.
- Outputs:
  - quotient/remainder update only on entry to DONE.
  - They hold that value through IDLE until the next completed division.
  - They are not disturbed during BUSY, so they keep the previous result.
- start while BUSY: ignored; no effect on operation or outputs.
- start held high continuously: re-accepted on each IDLE/DONE cycle, i.e. back-to-back divisions with no gap.
- Arithmetic invariant, for every divisor != 0: dividend = quotient*divisor + remainder and remainder < divisor.
- Divisor = 0 without the macro: the algorithm runs its full 2N cycles. Result: quotient = all ones, remainder = dividend[N-1:0].

Optional Feature:
- Macro: SEQ_DIVIDER_DZ_DETECT_EN.
- Defined:
  - divisor==0 at acceptance skips BUSY; DONE is entered on the next edge, so done arrives in cycle k+1.
  - dz=1 together with done and held with the result.
  - quotient = all ones; remainder = dividend[N-1:0].
  - dz clears on the next accepted start.
- Undefined:
  - dz tied to 0.
  - divide-by-zero takes the normal 2N-cycle path with the same quotient/remainder values as above.

Test Plan:
- Basic: start with dividend=42, divisor=5 -> done exactly 7 cycles after the accepting edge; quotient=8, remainder=2, dz=0.
- Extremes: 63/1 -> q=63, r=0. 7/7 -> q=1, r=0. 0/3 -> q=0, r=0. 62/7 -> q=8, r=6. Each done after 7 cycles.
- Handshake: start pulsed again 3 cycles into a 42/5 division with operands 9/2 -> ignored; result q=8, r=2. Holding start high through DONE -> next division starts with no idle gap; ready=0 during BUSY.
- Reset mid-op: assert rst during cycle 4 of 45/6 -> immediately IDLE, ready=1, outputs 0. A following 45/6 gives q=7, r=3.
- Divide-by-zero: 45/0.
  - With SEQ_DIVIDER_DZ_DETECT_EN: done at k+1, dz=1, q=63, r=5.
  - Without: done at k+7, dz=0, q=63, r=5.
- Randomized sweep: all 64x7 nonzero-divisor pairs checked against the invariant q*d + r == dividend, r < d.
